// File: rtl/prefix_seq_pkg.sv
// Shared types and helpers for the chunked prefix-add sequencer.
// Optional approximate-error tracking is enabled with PREFIX_SEQ_APPROX_ERR_EN.
package prefix_seq_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry out of a (propagate, generate) group given its carry in.
  function automatic logic chunk_cout(input logic p, input logic g, input logic cin);
    return g | (p & cin);
  endfunction

endpackage

// File: rtl/prefix_add_sequencer_slice.sv
// 8-bit exact Brent-Kung carry network: per-bit p/g plus carry in -> internal carries and carry out.
// With PREFIX_SEQ_APPROX_ERR_EN the full-chunk group generate/propagate is also exported.
module prefix_chunk_slice
  import prefix_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] p,
  input  logic [CHUNK_W-1:0] g,
  input  logic               cin,
  output logic [CHUNK_W-1:1] c,
  output logic               cout
`ifdef PREFIX_SEQ_APPROX_ERR_EN
  ,
  output logic               g_grp,
  output logic               p_grp
`endif
);

  // Up-sweep: pairs, then quads.
  logic g10, p10, g32, p32, g54, p54;
  logic g30, p30;
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;

  // Down-sweep fills in the remaining prefixes [i:0].
  logic g20, p20, g40, p40, g50, p50, g60, p60;
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;
  assign g40 = g[4] | (p[4] & g30);
  assign p40 = p[4] & p30;
  assign g50 = g54 | (p54 & g30);
  assign p50 = p54 & p30;
  assign g60 = g[6] | (p[6] & g50);
  assign p60 = p[6] & p50;

  logic [CHUNK_W-2:0] gp, pp;
  assign gp = {g60, g50, g40, g30, g20, g10, g[0]};
  assign pp = {p60, p50, p40, p30, p20, p10, p[0]};

  genvar gi;
  generate
    for (gi = 1; gi < CHUNK_W; gi++) begin : g_carry
      assign c[gi] = chunk_cout(pp[gi-1], gp[gi-1], cin);
    end
  endgenerate

  assign cout = chunk_cout(p[CHUNK_W-1], g[CHUNK_W-1], c[CHUNK_W-1]);

`ifdef PREFIX_SEQ_APPROX_ERR_EN
  logic g76, p76, g74, p74;
  assign g76   = g[7] | (p[7] & g[6]);
  assign p76   = p[7] & p[6];
  assign g74   = g76 | (p76 & g54);
  assign p74   = p76 & p54;
  assign g_grp = g74 | (p74 & g30);
  assign p_grp = p74 & p30;
`endif

endmodule

// File: rtl/prefix_add_sequencer.sv
// Multi-cycle wide adder: one 8-bit prefix slice reused LSB chunk first, with optional carry cutting.
// Define PREFIX_SEQ_APPROX_ERR_EN to add out_approx_err and the shadow exact carry.
module prefix_add_sequencer
  import prefix_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int APPROX_CHUNKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef PREFIX_SEQ_APPROX_ERR_EN
  ,
  output logic             out_approx_err
`endif
);

  localparam int NCH   = WIDTH / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NCH - 1);
  localparam logic [IDX_W-1:0] APPROX_LAST = IDX_W'(APPROX_CHUNKS);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             approx_reg, carry_reg, cout_reg;

  logic [CHUNK_W-1:0] a_chunk, b_chunk, p_chunk, g_chunk, sum_chunk;
  logic [CHUNK_W-1:1] c_w;
  logic [CHUNK_W-1:0] c_all;
  logic               cut_w, ci_w, chunk_cout_w;

  assign a_chunk = a_reg[idx_reg*CHUNK_W +: CHUNK_W];
  assign b_chunk = b_reg[idx_reg*CHUNK_W +: CHUNK_W];
  assign p_chunk = a_chunk ^ b_chunk;
  assign g_chunk = a_chunk & b_chunk;

  // Chunk 0 always sees the real carry in; only chunks 1..APPROX_CHUNKS can be cut.
  assign cut_w = approx_reg && (idx_reg != '0) && (idx_reg <= APPROX_LAST);
  assign ci_w  = cut_w ? 1'b0 : carry_reg;

`ifdef PREFIX_SEQ_APPROX_ERR_EN
  logic g_grp_w, p_grp_w;
  logic exact_c_reg, err_reg;
`endif

  prefix_chunk_slice u_slice (
    .p     (p_chunk),
    .g     (g_chunk),
    .cin   (ci_w),
    .c     (c_w),
    .cout  (chunk_cout_w)
`ifdef PREFIX_SEQ_APPROX_ERR_EN
    ,
    .g_grp (g_grp_w),
    .p_grp (p_grp_w)
`endif
  );

  assign c_all = {c_w, ci_w};

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK_W; gi++) begin : g_sum
      assign sum_chunk[gi] = p_chunk[gi] ^ c_all[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      approx_reg  <= 1'b0;
      carry_reg   <= 1'b0;
      cout_reg    <= 1'b0;
`ifdef PREFIX_SEQ_APPROX_ERR_EN
      exact_c_reg <= 1'b0;
      err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg       <= in_a;
            b_reg       <= in_b;
            approx_reg  <= in_approx;
            carry_reg   <= in_cin;
            idx_reg     <= '0;
            state_reg   <= S_RUN;
`ifdef PREFIX_SEQ_APPROX_ERR_EN
            exact_c_reg <= in_cin;
            err_reg     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          sum_reg[idx_reg*CHUNK_W +: CHUNK_W] <= sum_chunk;
          carry_reg <= chunk_cout_w;
          idx_reg   <= idx_reg + 1'b1;
`ifdef PREFIX_SEQ_APPROX_ERR_EN
          // The shadow carry never sees the cut, so it tracks the exact sum's carry chain.
          exact_c_reg <= chunk_cout(p_grp_w, g_grp_w, exact_c_reg);
          if (cut_w && exact_c_reg) begin
            err_reg <= 1'b1;
          end
`endif
          if (idx_reg == LAST_IDX) begin
            cout_reg  <= chunk_cout_w;
            idx_reg   <= '0;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
`ifdef PREFIX_SEQ_APPROX_ERR_EN
  assign out_approx_err = err_reg;
`endif

endmodule

// File: tb/tb_prefix_add_sequencer.sv
// Bench for prefix_add_sequencer: directed table, hand sequences and randomized transactions
// against a chunk-level arithmetic model. Error output is checked when PREFIX_SEQ_APPROX_ERR_EN is defined.
module tb_prefix_add_sequencer;

  localparam int WIDTH = 32;
  localparam int NCH   = WIDTH / 8;
  localparam int AC    = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_approx = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef PREFIX_SEQ_APPROX_ERR_EN
  logic             out_approx_err;
`endif

  always #5 clk = ~clk;

  prefix_add_sequencer #(.WIDTH(WIDTH), .APPROX_CHUNKS(AC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_approx (in_approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef PREFIX_SEQ_APPROX_ERR_EN
    ,
    .out_approx_err (out_approx_err)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_txn   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Chunk-wise reference: add 8 bits at a time, zeroing the carry into cut chunks.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic approx,
                                output logic [WIDTH-1:0] s, output logic co, output logic err);
    int carry;
    int t;
    logic [WIDTH:0] exact;
    carry = int'(cin);
    s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (approx && k >= 1 && k <= AC) carry = 0;
      t = int'(a[8*k +: 8]) + int'(b[8*k +: 8]) + carry;
      s[8*k +: 8] = t[7:0];
      carry = t / 256;
    end
    co = carry[0];
    exact = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    err = ({co, s} != exact);
  endfunction

  function automatic logic err_out();
`ifdef PREFIX_SEQ_APPROX_ERR_EN
    return out_approx_err;
`else
    return 1'b0;
`endif
  endfunction

  // Present one operand set, then scramble inputs and wait for out_valid; lat = cycles after accept.
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic approx,
                         output logic [WIDTH-1:0] s, output logic co, output logic err,
                         output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_approx = approx; in_valid = 1'b1;
    check("accept_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    in_cin = 1'($urandom); in_approx = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    s = out_sum; co = out_cout; err = err_out();
    n_txn++;
    $display("txn %0d a=%h b=%h cin=%0d approx=%0d sum=%h cout=%0d lat=%0d",
             n_txn, a, b, cin, approx, s, co, lat);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    check("drain_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             approx;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [WIDTH-1:0] s, ms, hold_sum;
    logic co, er, mco, mer;
    int lat;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FF00, 1'b0, 1'b1};
    vecs[2] = '{32'h00FF_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_FF00, 32'h0000_0100, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0080, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("rst_out_cout", {63'd0, out_cout}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {62'd0, busy, in_ready}, 64'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].approx, s, co, er, lat);
      check($sformatf("vec%0d_sum", i), {32'd0, s}, {32'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d_cout", i), {63'd0, co}, {63'd0, vecs[i].exp_cout});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(NCH));
`ifdef PREFIX_SEQ_APPROX_ERR_EN
      check($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
`endif
      drain();
    end

    // Backpressure: result held, new operands ignored
    run_txn(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, s, co, er, lat);
    hold_sum = s;
    in_valid = 1'b1;
    in_a = 32'h5555_5555;
    in_b = 32'h1111_1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_out_sum", {32'd0, out_sum}, {32'd0, 32'hDEAD_BEEF});
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    check("bp_sum_stable", {32'd0, out_sum}, {32'd0, hold_sum});
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("bp_no_accept", {63'd0, busy}, 64'd0);

    // Reset mid-RUN at idx=2
    @(negedge clk);
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b0; in_approx = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_out_sum", {32'd0, out_sum}, 64'd0);
    check("midrst_out_cout", {63'd0, out_cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, s, co, er, lat);
    check("after_rst_sum", {32'd0, s}, {32'd0, 32'h2345_678A});
    check("after_rst_cout", {63'd0, co}, 64'd0);
    drain();

    // Randomized against the chunk model, with random sink stalls
    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rc, rx;
      int stall;
      ra = $urandom; rb = $urandom;
      if (i % 3 == 0) rb = ~ra;
      rc = 1'($urandom); rx = 1'($urandom);
      model(ra, rb, rc, rx, ms, mco, mer);
      run_txn(ra, rb, rc, rx, s, co, er, lat);
      check("rand_sum", {32'd0, s}, {32'd0, ms});
      check("rand_cout", {63'd0, co}, {63'd0, mco});
      check("rand_lat", 64'(lat), 64'(NCH));
`ifdef PREFIX_SEQ_APPROX_ERR_EN
      check("rand_err", {63'd0, er}, {63'd0, mer});
`endif
      stall = int'($urandom_range(0, 2));
      repeat (stall) @(negedge clk);
      if (stall > 0) check("rand_hold_sum", {32'd0, out_sum}, {32'd0, ms});
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
